// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, requests to send,
// shifts out one byte with odd parity on device clock edges and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES  = 5000,
  parameter int RTS_HOLD_CYCLES = 50,
  parameter int START_TIMEOUT   = 750000,
  parameter int PACKET_TIMEOUT  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_no_ack,
  output logic       error_communication_timed_out
);

  localparam logic [19:0] INHIBIT_LD = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] RTS_LD     = 20'(RTS_HOLD_CYCLES - 1);
  localparam logic [19:0] START_LD   = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] PACKET_LD  = 20'(PACKET_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_WAIT_FIRST, S_XFER,
    S_WAIT_IDLE, S_DONE, S_FAIL_TMO, S_FAIL_NACK
  } state_t;

  state_t      state, state_nx;
  logic        clk_p0, clk_p1, clk_p2;
  logic        dat_p0, dat_p1;
  logic        req_p0;
  logic [7:0]  cmd_p0;
  logic [7:0]  sh;
  logic        par;
  logic        dat_bit;
  logic [3:0]  edge_cnt;
  logic [19:0] tmo;
  logic [19:0] tmo_dec;
  logic        tmo_zero;
  logic        fe;
  logic        clk_low;
  logic        dat_low;

  // Stage p0/p1: line synchronizers; p2 holds the previous clock for edge detect
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
      req_p0 <= 1'b0;
    end else begin
      clk_p0 <= PS2_CLK;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= PS2_DAT;
      dat_p1 <= dat_p0;
      req_p0 <= send_command;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    cmd_p0 <= the_command;
  end

  assign fe       = clk_p2 & ~clk_p1;
  assign tmo_zero = (tmo == 20'd0);
  assign tmo_dec  = tmo_zero ? 20'd0 : tmo - 20'd1;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx                      = state;
    busy                          = (state != S_IDLE);
    command_was_sent              = 1'b0;
    error_no_ack                  = 1'b0;
    error_communication_timed_out = 1'b0;
    case (state)
      S_IDLE:       if (req_p0) state_nx = S_INHIBIT;
      S_INHIBIT:    if (tmo_zero) state_nx = S_RTS;
      S_RTS:        if (tmo_zero) state_nx = S_WAIT_FIRST;
      S_WAIT_FIRST: begin
        if (fe)            state_nx = S_XFER;
        else if (tmo_zero) state_nx = S_FAIL_TMO;
      end
      // A device edge arriving with the timeout expiry takes precedence
      S_XFER: begin
        if (fe) begin
          if (edge_cnt == 4'd10) state_nx = dat_p1 ? S_FAIL_NACK : S_WAIT_IDLE;
        end else if (tmo_zero) begin
          state_nx = S_FAIL_TMO;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_p1 && dat_p1) state_nx = S_DONE;
        else if (tmo_zero)    state_nx = S_FAIL_TMO;
      end
      S_DONE: begin
        command_was_sent = 1'b1;
        state_nx         = S_IDLE;
      end
      S_FAIL_TMO: begin
        error_communication_timed_out = 1'b1;
        state_nx                      = S_IDLE;
      end
      S_FAIL_NACK: begin
        error_no_ack = 1'b1;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Timer reloads on entry to each timed state; the packet window spans XFER and WAIT_IDLE
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo <= 20'd0;
    end else if (state_nx != state) begin
      case (state_nx)
        S_INHIBIT:    tmo <= INHIBIT_LD;
        S_RTS:        tmo <= RTS_LD;
        S_WAIT_FIRST: tmo <= START_LD;
        S_XFER:       tmo <= PACKET_LD;
        S_WAIT_IDLE:  tmo <= tmo_dec;
        default:      tmo <= 20'd0;
      endcase
    end else begin
      tmo <= tmo_dec;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      edge_cnt <= 4'd0;
      dat_bit  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          edge_cnt <= 4'd0;
          dat_bit  <= 1'b1;
        end
        S_RTS: dat_bit <= 1'b0;
        S_WAIT_FIRST: begin
          if (fe) begin
            dat_bit  <= sh[0];
            edge_cnt <= 4'd1;
          end
        end
        S_XFER: begin
          if (fe) begin
            edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt <= 4'd7)      dat_bit <= sh[0];
            else if (edge_cnt == 4'd8) dat_bit <= par;
            else                       dat_bit <= 1'b1;
          end
        end
        default: dat_bit <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (state == S_IDLE && req_p0) begin
      sh  <= cmd_p0;
      par <= ~^cmd_p0;
    end else if ((state == S_WAIT_FIRST || state == S_XFER) && fe) begin
      sh <= {1'b0, sh[7:1]};
    end
  end

  // Open-drain pads decoded from registered state so reset releases them at once
  assign clk_low = (state == S_INHIBIT) || (state == S_RTS);
  assign dat_low = (state == S_RTS) ||
                   (((state == S_WAIT_FIRST) || (state == S_XFER)) && !dat_bit);

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on the bus.
module tb_ps2_host_tx;

  localparam int INH   = 5000;
  localparam int RTSH  = 50;
  localparam int START = 2000;
  localparam int PKT   = 4000;
  localparam int HALF  = 40;

  logic       CLOCK_50     = 1'b0;
  logic       RESET_N      = 1'b1;
  logic [7:0] the_command  = 8'h00;
  logic       send_command = 1'b0;
  logic       busy, command_was_sent, error_no_ack, error_communication_timed_out;
  wire        ps2_clk, ps2_dat;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_HOLD_CYCLES(RTSH),
    .START_TIMEOUT  (START),
    .PACKET_TIMEOUT (PKT)
  ) dut (
    .CLOCK_50                     (CLOCK_50),
    .RESET_N                      (RESET_N),
    .the_command                  (the_command),
    .send_command                 (send_command),
    .PS2_CLK                      (ps2_clk),
    .PS2_DAT                      (ps2_dat),
    .busy                         (busy),
    .command_was_sent             (command_was_sent),
    .error_no_ack                 (error_no_ack),
    .error_communication_timed_out(error_communication_timed_out)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_sent  = 0;
  int   n_nack  = 0;
  int   n_tmo   = 0;
  int   n_multi = 0;
  int   n_long  = 0;
  logic any_prev = 1'b0;

  always @(negedge CLOCK_50) begin
    if (command_was_sent) n_sent <= n_sent + 1;
    if (error_no_ack) n_nack <= n_nack + 1;
    if (error_communication_timed_out) n_tmo <= n_tmo + 1;
    if ((32'(command_was_sent) + 32'(error_no_ack) + 32'(error_communication_timed_out)) > 1)
      n_multi <= n_multi + 1;
    if (any_prev && (command_was_sent || error_no_ack || error_communication_timed_out))
      n_long <= n_long + 1;
    any_prev <= command_was_sent || error_no_ack || error_communication_timed_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic start(input logic [7:0] c);
    the_command  = c;
    send_command = 1'b1;
    cyc(1);
    send_command = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (busy !== 1'b0 && g < 2000) begin
      cyc(1);
      g++;
    end
    check(tag, 32'(busy), 32'd0);
    cyc(2);
  endtask

  // Keyboard model: measures the inhibit/RTS phases, clocks 11 edges, samples on rising edges
  task automatic device(input int ack, input int abort_at, input int repulse_at,
                        output logic [9:0] bits, output int inh_cnt, output int rts_cnt);
    int guard = 0;
    bits    = '0;
    inh_cnt = 0;
    rts_cnt = 0;
    while (ps2_clk !== 1'b0 && guard < 100) begin
      cyc(1);
      guard++;
    end
    check("host_clk_low", 32'(ps2_clk), 32'd0);
    guard = 0;
    while (ps2_clk === 1'b0 && guard < 20000) begin
      if (ps2_dat === 1'b1) inh_cnt++;
      else                  rts_cnt++;
      cyc(1);
      guard++;
    end
    check("start_bit", 32'(ps2_dat), 32'd0);
    cyc(100);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == repulse_at) begin
        the_command  = 8'h55;
        send_command = 1'b1;
        cyc(1);
        send_command = 1'b0;
        cyc(HALF - 1);
      end else begin
        cyc(HALF);
      end
      dev_clk_low = 1'b0;
      bits[i-1]   = ps2_dat;
      if (i == abort_at) begin
        cyc(3);
        check("pre_reset_dat", 32'(ps2_dat), 32'd0);
        #3;
        RESET_N = 1'b0;
        #1;
        check("reset_dat_released", 32'(ps2_dat), 32'd1);
        check("reset_clk_released", 32'(ps2_clk), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        return;
      end
      cyc(HALF);
    end
    if (ack != 0) dev_dat_low = 1'b1;
    cyc(5);
    dev_clk_low = 1'b1;
    cyc(HALF);
    dev_clk_low = 1'b0;
    cyc(HALF);
    dev_dat_low = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    int inh, rts, s0, k0, t0, cnt;

    #1 RESET_N = 1'b0;
    cyc(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sent", 32'(command_was_sent), 32'd0);
    check("rst_nack", 32'(error_no_ack), 32'd0);
    check("rst_tmo", 32'(error_communication_timed_out), 32'd0);
    check("rst_clk", 32'(ps2_clk), 32'd1);
    check("rst_dat", 32'(ps2_dat), 32'd1);
    RESET_N = 1'b1;
    cyc(2);

    // 0xED with start-latency check
    s0 = n_sent; k0 = n_nack; t0 = n_tmo;
    start(8'hED);
    check("latency_busy_n", 32'(busy), 32'd0);
    cyc(1);
    check("latency_busy_n1", 32'(busy), 32'd1);
    check("latency_clk_n1", 32'(ps2_clk), 32'd0);
    device(1, 0, 0, bits, inh, rts);
    check("ed_bits", 32'(bits), 32'h3ED);
    check("ed_inhibit", 32'(inh), 32'(INH));
    check("ed_rts", 32'(rts), 32'(RTSH));
    wait_idle("ed_idle");
    check("ed_sent", 32'(n_sent - s0), 32'd1);
    check("ed_nack", 32'(n_nack - k0), 32'd0);
    check("ed_tmo", 32'(n_tmo - t0), 32'd0);
    check("ed_clk_rel", 32'(ps2_clk), 32'd1);
    check("ed_dat_rel", 32'(ps2_dat), 32'd1);

    // 0xF4 with a second request pulsed mid-transfer
    s0 = n_sent;
    start(8'hF4);
    device(1, 0, 3, bits, inh, rts);
    check("f4_bits", 32'(bits), 32'h2F4);
    check("f4_inhibit", 32'(inh), 32'(INH));
    wait_idle("f4_idle");
    check("f4_sent", 32'(n_sent - s0), 32'd1);
    cyc(300);
    check("repulse_busy", 32'(busy), 32'd0);
    check("repulse_clk", 32'(ps2_clk), 32'd1);
    check("repulse_sent", 32'(n_sent - s0), 32'd1);

    // 0x00: parity 1
    s0 = n_sent;
    start(8'h00);
    device(1, 0, 0, bits, inh, rts);
    check("z_bits", 32'(bits), 32'h300);
    check("z_inhibit", 32'(inh), 32'(INH));
    wait_idle("z_idle");
    check("z_sent", 32'(n_sent - s0), 32'd1);

    // Device never clocks
    t0 = n_tmo; s0 = n_sent;
    start(8'hF4);
    cyc(1);
    cnt = 0;
    while (error_communication_timed_out !== 1'b1 && cnt < 20000) begin
      cyc(1);
      cnt++;
    end
    check("tmo_latency", 32'(cnt), 32'(INH + RTSH + START));
    check("tmo_clk_rel", 32'(ps2_clk), 32'd1);
    check("tmo_dat_rel", 32'(ps2_dat), 32'd1);
    cyc(1);
    check("tmo_busy_after", 32'(busy), 32'd0);
    cyc(2);
    check("tmo_pulse", 32'(n_tmo - t0), 32'd1);
    check("tmo_no_sent", 32'(n_sent - s0), 32'd0);

    // Device withholds the ACK
    s0 = n_sent; k0 = n_nack;
    start(8'h00);
    device(0, 0, 0, bits, inh, rts);
    wait_idle("nack_idle");
    check("nack_pulse", 32'(n_nack - k0), 32'd1);
    check("nack_no_sent", 32'(n_sent - s0), 32'd0);

    // Reset mid-transfer after the fifth edge
    s0 = n_sent; k0 = n_nack; t0 = n_tmo;
    start(8'h00);
    device(1, 5, 0, bits, inh, rts);
    cyc(2);
    RESET_N = 1'b1;
    cyc(200);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pulses", 32'((n_sent - s0) + (n_nack - k0) + (n_tmo - t0)), 32'd0);

    // 0xFF after reset
    s0 = n_sent;
    start(8'hFF);
    device(1, 0, 0, bits, inh, rts);
    check("ff_bits", 32'(bits), 32'h3FF);
    wait_idle("ff_idle");
    check("ff_sent", 32'(n_sent - s0), 32'd1);

    check("pulse_exclusive", 32'(n_multi), 32'd0);
    check("pulse_width", 32'(n_long), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
